// File: rtl/multdiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the iterative
// multiply/divide sequencer: request, operands, result and status flags.
interface multdiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             stall_out;
  logic             mult_exception;
  logic             div_exception;

  // Pipeline side: issues requests and consumes results.
  modport master (
    output start, op, operand_a, operand_b,
    input  result, done, busy, stall_out, mult_exception, div_exception
  );

  // Sequencer side.
  modport slave (
    input  start, op, operand_a, operand_b,
    output result, done, busy, stall_out, mult_exception, div_exception
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide unit. Operands are reduced to magnitudes
// on accept, a 32-step shift-add multiply or restoring divide runs in RUN,
// and the sign-corrected result plus exception flags are registered on the
// final step and presented for one cycle in DONE.
module multdiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                clock,
  input logic                reset,
  multdiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [4:0]       cnt_q;
  logic             op_q;
  logic             sign_q;
  logic [WIDTH-1:0] m_q;      // |a| for multiply, |b| (divisor) for divide
  logic [WIDTH-1:0] hi_q;     // product high half, or remainder
  logic [WIDTH-1:0] lo_q;     // multiplier/product low half, or quotient
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             busy_q;
  logic             mult_exc_q;
  logic             div_exc_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   hi_mul_d;
  logic [WIDTH-1:0]   lo_mul_d;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH-1:0]   hi_div_d;
  logic [WIDTH-1:0]   lo_div_d;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic               mult_ovf;

  // One iteration step of either algorithm plus the sign-fixed final values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    a_mag     = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    b_mag     = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

    // Shift-add multiply: 33-bit add into hi, then shift {carry,hi,lo} right.
    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    hi_mul_d  = add_sum[WIDTH:1];
    lo_mul_d  = {add_sum[0], lo_q[WIDTH-1:1]};

    // Restoring divide: shift {R,Q} left, keep R-|b| if it did not borrow.
    // R stays below |b| <= 2^31, so a 32-bit register plus the shifted-in
    // bit is enough to hold the 33-bit partial remainder.
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, m_q};
    hi_div_d  = rem_shift[WIDTH-1:0];
    lo_div_d  = {lo_q[WIDTH-2:0], 1'b0};
    if (!rem_diff[WIDTH]) begin
      hi_div_d = rem_diff[WIDTH-1:0];
      lo_div_d = {lo_q[WIDTH-2:0], 1'b1};
    end

    hi_d        = op_q ? hi_div_d : hi_mul_d;
    lo_d        = op_q ? lo_div_d : lo_mul_d;

    prod        = {hi_mul_d, lo_mul_d};
    prod_signed = sign_q ? -prod : prod;
    quot_signed = sign_q ? -lo_div_d : lo_div_d;
    // Signed product fits in 32 bits only if bits 63..31 are a pure sign run.
    mult_ovf    = (|prod_signed[2*WIDTH-1:WIDTH-1]) &&
                  !(&prod_signed[2*WIDTH-1:WIDTH-1]);
  end

  // Sequencing FSM with registered result, flags, done and busy.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the datapath registers are reset along with control because
    // result and the flags are visible outputs that must read 0 after reset.
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      sign_q     <= 1'b0;
      m_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mult_exc_q <= 1'b0;
      div_exc_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q       <= bus.op;
            sign_q     <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
            cnt_q      <= '0;
            hi_q       <= '0;
            result_q   <= '0;
            mult_exc_q <= 1'b0;
            div_exc_q  <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.op) begin
              m_q  <= b_mag;
              lo_q <= a_mag;
            end else begin
              m_q  <= a_mag;
              lo_q <= b_mag;
            end
            if (bus.op && (bus.operand_b == '0)) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              div_exc_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end else if (state_q == S_DONE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 5'd1;
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          if (cnt_q == 5'd31) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (op_q) begin
              result_q <= quot_signed;
            end else begin
              result_q   <= prod_signed[WIDTH-1:0];
              mult_exc_q <= mult_ovf;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result         = result_q;
  assign bus.done           = done_q;
  assign bus.busy           = busy_q;
  assign bus.mult_exception = mult_exc_q;
  assign bus.div_exception  = div_exc_q;
  // Hold the pipeline from the request cycle through the last RUN cycle.
  assign bus.stall_out      = (bus.start && ((state_q == S_IDLE) || (state_q == S_DONE)))
                              || (state_q == S_RUN);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nfail;
  int   stall_cycles;
  bit   count_stall;
  int   lat;
  int   done_seen;

  multdiv_sequencer_if #(.WIDTH(32)) bus ();

  multdiv_sequencer #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall duration, sampled mid-cycle.
  always @(negedge clk) if (count_stall && bus.stall_out) stall_cycles++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns 1ns after the accepting edge.
  task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Cycles from the accepting edge to the cycle in which done is high.
  // With jitter set, start and operands are scrambled every RUN cycle.
  task automatic wait_done(input bit jitter, output int cycles);
    cycles = 1;
    while (!bus.done && cycles < 100) begin
      if (jitter) begin
        bus.start     = ~bus.start;
        bus.op        = 1'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
      end
      tick();
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0; nfail = 0; stall_cycles = 0; count_stall = 0; done_seen = 0;
    bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    rst_n = 1'b0;
    #3;
    check("rst_result", bus.result, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.mult_exception, bus.div_exception}, 0);
    check("rst_stall", bus.stall_out, 0);
    bus.start = 1'b1;
    #1;
    check("rst_stall_start", bus.stall_out, 1);
    bus.start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 7 * -3
    stall_cycles = 0; count_stall = 1;
    start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    check("mul1_busy", bus.busy, 1);
    wait_done(1'b0, lat);
    check("mul1_latency", lat, 33);
    check("mul1_result", bus.result, 32'hFFFF_FFEB);
    check("mul1_flags", {bus.mult_exception, bus.div_exception}, 0);
    check("mul1_stall_in_done", bus.stall_out, 0);
    tick();
    count_stall = 0;
    check("mul1_done_pulse", bus.done, 0);
    check("mul1_idle_busy", bus.busy, 0);
    check("mul1_stall_cycles", stall_cycles, 33);

    // Overflow: 2^16 * 2^16
    start_op(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done(1'b0, lat);
    check("ovf_latency", lat, 33);
    check("ovf_result", bus.result, 0);
    check("ovf_mexc", bus.mult_exception, 1);
    check("ovf_dexc", bus.div_exception, 0);
    repeat (5) tick();
    check("ovf_hold_mexc", bus.mult_exception, 1);
    check("ovf_hold_result", bus.result, 0);

    // -2^31 * 1 fits exactly
    start_op(1'b0, 32'h8000_0000, 32'd1);
    wait_done(1'b0, lat);
    check("minmul_result", bus.result, 32'h8000_0000);
    check("minmul_mexc", bus.mult_exception, 0);
    tick();

    // -7 / 2
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0, lat);
    check("div1_latency", lat, 33);
    check("div1_result", bus.result, 32'hFFFF_FFFD);
    check("div1_flags", {bus.mult_exception, bus.div_exception}, 0);
    tick();

    // -2^31 / -1
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, lat);
    check("divmin_result", bus.result, 32'h8000_0000);
    check("divmin_flags", {bus.mult_exception, bus.div_exception}, 0);
    tick();

    // 1000 / -7 = -142
    start_op(1'b1, 32'd1000, 32'hFFFF_FFF9);
    wait_done(1'b0, lat);
    check("div2_result", bus.result, 32'hFFFF_FF72);
    tick();

    // 5 / 0
    stall_cycles = 0; count_stall = 1;
    start_op(1'b1, 32'd5, 32'd0);
    wait_done(1'b0, lat);
    check("dz_latency", lat, 1);
    check("dz_result", bus.result, 0);
    check("dz_dexc", bus.div_exception, 1);
    check("dz_mexc", bus.mult_exception, 0);
    tick();
    count_stall = 0;
    check("dz_stall_cycles", stall_cycles, 1);
    check("dz_done_pulse", bus.done, 0);
    check("dz_hold_dexc", bus.div_exception, 1);

    // Reset mid-RUN
    start_op(1'b0, 32'd3, 32'd4);
    repeat (9) tick();
    check("rmid_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rmid_busy", bus.busy, 0);
    check("rmid_done", bus.done, 0);
    check("rmid_result", bus.result, 0);
    check("rmid_stall", bus.stall_out, 0);
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("rmid_no_done", done_seen, 0);
    start_op(1'b0, 32'd6, 32'd6);
    wait_done(1'b0, lat);
    check("rmid_6x6_latency", lat, 33);
    check("rmid_6x6_result", bus.result, 32'd36);
    tick();

    // Overlapping requests and back-to-back accept
    start_op(1'b0, 32'd100, 32'hFFFF_FFFB);
    wait_done(1'b1, lat);
    check("ovl_latency", lat, 33);
    check("ovl_result", bus.result, 32'hFFFF_FE0C);
    check("ovl_flags", {bus.mult_exception, bus.div_exception}, 0);
    start_op(1'b0, 32'h0000_1234, 32'h0000_0010);
    check("b2b_done_low", bus.done, 0);
    check("b2b_busy", bus.busy, 1);
    check("b2b_stall", bus.stall_out, 1);
    wait_done(1'b0, lat);
    check("b2b_gap", lat, 33);
    check("b2b_result", bus.result, 32'h0001_2340);
    tick();
    check("b2b_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
